// File: rtl/sensor_conditioner_pkg.sv
// Shared constants and lane state encoding for the four-lane loop-detector conditioner.
package sensor_conditioner_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_N    = 0;
    localparam int LANE_E    = 1;
    localparam int LANE_S    = 2;
    localparam int LANE_W    = 3;

    localparam int DEFAULT_DEBOUNCE = 4;
    localparam int DEFAULT_HOLD     = 8;
    localparam int DEFAULT_STUCK    = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUAL_ON,
        ST_PRESENT,
        ST_QUAL_OFF,
        ST_HOLD
    } laneState_t;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw loop levels in, qualified presence, vehicle counts and stuck-loop flags out.
interface sensor_conditioner_if;
    import sensor_conditioner_pkg::*;

    logic                 raw_north;
    logic                 raw_east;
    logic                 raw_south;
    logic                 raw_west;
    logic                 clr_counts;
    logic                 sensor_north;
    logic                 sensor_east;
    logic                 sensor_south;
    logic                 sensor_west;
    logic [31:0]          veh_count;
    logic [NUM_LANES-1:0] fault;

    modport master (
        output raw_north, raw_east, raw_south, raw_west, clr_counts,
        input  sensor_north, sensor_east, sensor_south, sensor_west, veh_count, fault
    );

    modport slave (
        input  raw_north, raw_east, raw_south, raw_west, clr_counts,
        output sensor_north, sensor_east, sensor_south, sensor_west, veh_count, fault
    );

endinterface

// File: rtl/sensor_conditioner_lane_qualifier.sv
// One lane: debounce/hold FSM on the synchronised loop level, saturating vehicle
// count and a sticky stuck-loop flag that forces presence on as a fail-safe.
module lane_qualifier
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int unsigned HOLD     = DEFAULT_HOLD,
    parameter int unsigned STUCK    = DEFAULT_STUCK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_in_i,
    input  logic       clr_i,
    output logic       sensor_o,
    output logic [7:0] count_o,
    output logic       fault_o
);

    localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD);
    localparam logic [15:0] STUCK_LIM = 16'(STUCK);
    localparam bit          DIRECT    = (DEBOUNCE == 1);

    laneState_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sensor_q, sensor_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] stuck_q, stuck_d;
    logic        fault_q, fault_d;
    logic        out_q, out_d;
    logic        enterPresent;
    logic        inPresent;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sensor_d     = sensor_q;
        enterPresent = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s_in_i) begin
                    if (DIRECT) begin
                        state_d      = ST_PRESENT;
                        sensor_d     = 1'b1;
                        enterPresent = 1'b1;
                    end else begin
                        state_d = ST_QUAL_ON;
                        cnt_d   = 8'd1;
                    end
                end
            end
            ST_QUAL_ON: begin
                if (!s_in_i) begin
                    state_d  = ST_IDLE;
                    sensor_d = 1'b0;
                    cnt_d    = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d      = ST_PRESENT;
                    sensor_d     = 1'b1;
                    enterPresent = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PRESENT: begin
                if (!s_in_i) begin
                    state_d = DIRECT ? ST_HOLD : ST_QUAL_OFF;
                    cnt_d   = 8'd1;
                end
            end
            ST_QUAL_OFF: begin
                if (s_in_i) begin
                    state_d = ST_PRESENT;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                // A returning vehicle must requalify; presence is held meanwhile.
                if (s_in_i) begin
                    if (DIRECT) begin
                        state_d      = ST_PRESENT;
                        enterPresent = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        state_d = ST_QUAL_ON;
                        cnt_d   = 8'd1;
                    end
                end else if (cnt_q >= HOLD_LAST) begin
                    state_d  = ST_IDLE;
                    sensor_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sensor_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // Counting, stuck detection and the clear all resolve here so clear wins.
    always_comb begin
        inPresent = (state_q == ST_PRESENT);
        stuck_d   = '0;
        if (inPresent) begin
            stuck_d = (stuck_q >= STUCK_LIM) ? stuck_q : stuck_q + 16'd1;
        end
        fault_d = fault_q | (inPresent && (({1'b0, stuck_q} + 17'd1) >= {1'b0, STUCK_LIM}));
        count_d = count_q;
        if (enterPresent && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
        if (clr_i) begin
            count_d = '0;
            fault_d = 1'b0;
        end
        out_d = sensor_d | fault_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sensor_q <= 1'b0;
            count_q  <= '0;
            stuck_q  <= '0;
            fault_q  <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sensor_q <= sensor_d;
            count_q  <= count_d;
            stuck_q  <= stuck_d;
            fault_q  <= fault_d;
            out_q    <= out_d;
        end
    end

    assign sensor_o = out_q;
    assign count_o  = count_q;
    assign fault_o  = fault_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Four independent loop-detector lanes: two-flop synchronisers, one lane_qualifier
// per approach, and packing of presence, counts and fault flags onto the bus.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int unsigned HOLD     = DEFAULT_HOLD,
    parameter int unsigned STUCK    = DEFAULT_STUCK
) (
    input logic                 clk,
    input logic                 rst,
    sensor_conditioner_if.slave bus
);

    logic [NUM_LANES-1:0] rawVec;
    logic [NUM_LANES-1:0] sync1_q;
    logic [NUM_LANES-1:0] sync2_q;
    logic [NUM_LANES-1:0] sensorVec;
    logic [NUM_LANES-1:0] faultVec;
    logic [7:0]           countVec [NUM_LANES];

    assign rawVec[LANE_N] = bus.raw_north;
    assign rawVec[LANE_E] = bus.raw_east;
    assign rawVec[LANE_S] = bus.raw_south;
    assign rawVec[LANE_W] = bus.raw_west;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawVec;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_qualifier #(
            .DEBOUNCE (DEBOUNCE),
            .HOLD     (HOLD),
            .STUCK    (STUCK)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s_in_i   (sync2_q[i]),
            .clr_i    (bus.clr_counts),
            .sensor_o (sensorVec[i]),
            .count_o  (countVec[i]),
            .fault_o  (faultVec[i])
        );
    end

    assign bus.sensor_north = sensorVec[LANE_N];
    assign bus.sensor_east  = sensorVec[LANE_E];
    assign bus.sensor_south = sensorVec[LANE_S];
    assign bus.sensor_west  = sensorVec[LANE_W];
    assign bus.veh_count    = {countVec[LANE_W], countVec[LANE_S], countVec[LANE_E], countVec[LANE_N]};
    assign bus.fault        = faultVec;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: vector table, corner-case sequences and a random
// run, all compared cycle by cycle against a run-length model of lane behaviour.
module tb_sensor_conditioner;
    import sensor_conditioner_pkg::*;

    localparam int DEB = DEFAULT_DEBOUNCE;
    localparam int HLD = DEFAULT_HOLD;
    localparam int STK = DEFAULT_STUCK;

    logic clk = 1'b0;
    logic rst;

    sensor_conditioner_if bus();

    sensor_conditioner #(
        .DEBOUNCE (DEB),
        .HOLD     (HLD),
        .STUCK    (STK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: a lane is qualified once DEB equal samples in a row disagree with
    // its current level; a release keeps presence for HLD more zero samples
    // unless a short, unqualified blip interrupts it.
    bit mSync1 [4];
    bit mSync2 [4];
    bit mQ [4];
    bit mExt [4];
    bit mFault [4];
    bit mPrevPresent [4];
    int mOneRun [4];
    int mZeroRun [4];
    int mPresentRun [4];
    int mCount [4];

    typedef struct {
        logic [3:0]  raw;
        logic        clr;
        logic        rstIn;
        int          cycles;
        logic [3:0]  expSensor;
        logic [31:0] expCount;
        logic [3:0]  expFault;
        string       name;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [3:0] dutSensor();
        return {bus.sensor_west, bus.sensor_south, bus.sensor_east, bus.sensor_north};
    endfunction

    function automatic logic [3:0] modelSensor();
        logic [3:0] s;
        for (int l = 0; l < 4; l++) s[l] = mQ[l] | mExt[l] | mFault[l];
        return s;
    endfunction

    function automatic logic [31:0] modelCounts();
        return {mCount[3][7:0], mCount[2][7:0], mCount[1][7:0], mCount[0][7:0]};
    endfunction

    function automatic logic [3:0] modelFault();
        return {mFault[3], mFault[2], mFault[1], mFault[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input logic [3:0] raw, input logic clr, input logic rstIn);
        bit s;
        for (int l = 0; l < 4; l++) begin
            if (rstIn) begin
                mSync1[l] = 0; mSync2[l] = 0; mQ[l] = 0; mExt[l] = 0; mFault[l] = 0;
                mPrevPresent[l] = 0; mOneRun[l] = 0; mZeroRun[l] = 0;
                mPresentRun[l] = 0; mCount[l] = 0;
            end else begin
                s = mSync2[l];
                mSync2[l] = mSync1[l];
                mSync1[l] = raw[l];
                if (mPrevPresent[l]) begin
                    mPresentRun[l]++;
                    if (mPresentRun[l] >= STK) mFault[l] = 1;
                end else begin
                    mPresentRun[l] = 0;
                end
                if (s) begin
                    mOneRun[l]++;
                    mZeroRun[l] = 0;
                    if (!mQ[l] && mOneRun[l] == DEB) begin
                        mQ[l] = 1;
                        mExt[l] = 0;
                        if (mCount[l] < 255) mCount[l]++;
                    end
                end else begin
                    if (!mQ[l] && mOneRun[l] > 0) mExt[l] = 0;
                    mOneRun[l] = 0;
                    mZeroRun[l]++;
                    if (mQ[l] && mZeroRun[l] == DEB) begin
                        mQ[l] = 0;
                        mExt[l] = 1;
                    end else if (!mQ[l] && mExt[l] && mZeroRun[l] == DEB + HLD) begin
                        mExt[l] = 0;
                    end
                end
                mPrevPresent[l] = mQ[l] && (mZeroRun[l] == 0);
                if (clr) begin
                    mCount[l] = 0;
                    mFault[l] = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic clr, input logic rstIn, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rst            = rstIn;
            bus.raw_north  = raw[0];
            bus.raw_east   = raw[1];
            bus.raw_south  = raw[2];
            bus.raw_west   = raw[3];
            bus.clr_counts = clr;
            modelStep(raw, clr, rstIn);
            @(posedge clk);
            #1;
            checkOutput("model_sensor", {28'd0, dutSensor()}, {28'd0, modelSensor()});
            checkOutput("model_count", bus.veh_count, modelCounts());
            checkOutput("model_fault", {28'd0, bus.fault}, {28'd0, modelFault()});
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] r;
        logic       eastSeen;

        vecs[0]  = '{4'b0000, 1'b0, 1'b1, 2,  4'b0000, 32'h0000_0000, 4'b0000, "reset"};
        vecs[1]  = '{4'b0001, 1'b0, 1'b0, 5,  4'b0000, 32'h0000_0000, 4'b0000, "north_pre_rise"};
        vecs[2]  = '{4'b0001, 1'b0, 1'b0, 1,  4'b0001, 32'h0000_0001, 4'b0000, "north_rise"};
        vecs[3]  = '{4'b0001, 1'b0, 1'b0, 14, 4'b0001, 32'h0000_0001, 4'b0000, "north_held"};
        vecs[4]  = '{4'b0000, 1'b0, 1'b0, 13, 4'b0001, 32'h0000_0001, 4'b0000, "north_hold_ext"};
        vecs[5]  = '{4'b0000, 1'b0, 1'b0, 1,  4'b0000, 32'h0000_0001, 4'b0000, "north_fall"};
        vecs[6]  = '{4'b0100, 1'b0, 1'b0, 10, 4'b0100, 32'h0001_0001, 4'b0000, "south_first"};
        vecs[7]  = '{4'b0000, 1'b0, 1'b0, 5,  4'b0100, 32'h0001_0001, 4'b0000, "south_gap"};
        vecs[8]  = '{4'b0100, 1'b0, 1'b0, 10, 4'b0100, 32'h0002_0001, 4'b0000, "south_second"};
        vecs[9]  = '{4'b0000, 1'b0, 1'b0, 13, 4'b0100, 32'h0002_0001, 4'b0000, "south_hold"};
        vecs[10] = '{4'b0000, 1'b0, 1'b0, 1,  4'b0000, 32'h0002_0001, 4'b0000, "south_fall"};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 1,  4'b0000, 32'h0000_0000, 4'b0000, "clear"};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].raw, vecs[i].clr, vecs[i].rstIn, vecs[i].cycles);
            checkOutput({vecs[i].name, "_sensor"}, {28'd0, dutSensor()}, {28'd0, vecs[i].expSensor});
            checkOutput({vecs[i].name, "_count"}, bus.veh_count, vecs[i].expCount);
            checkOutput({vecs[i].name, "_fault"}, {28'd0, bus.fault}, {28'd0, vecs[i].expFault});
        end

        // Short east blips never qualify.
        eastSeen = 1'b0;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 13; c++) begin
                applyStimulus((c < 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1);
                eastSeen = eastSeen | bus.sensor_east;
            end
        end
        checkOutput("east_blip_sensor", {31'd0, eastSeen}, 32'd0);
        checkOutput("east_blip_count", {24'd0, bus.veh_count[15:8]}, 32'd0);

        // Stuck west loop: flag near 1006 edges, fail-safe presence until cleared.
        applyStimulus(4'b1000, 1'b0, 1'b0, 1004);
        checkOutput("stuck_before", {31'd0, bus.fault[3]}, 32'd0);
        applyStimulus(4'b1000, 1'b0, 1'b0, 3);
        checkOutput("stuck_set", {31'd0, bus.fault[3]}, 32'd1);
        applyStimulus(4'b1000, 1'b0, 1'b0, 93);
        applyStimulus(4'b0000, 1'b0, 1'b0, 30);
        checkOutput("stuck_failsafe", {31'd0, bus.sensor_west}, 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("stuck_clr_fault", {28'd0, bus.fault}, 32'd0);
        checkOutput("stuck_clr_sensor", {31'd0, bus.sensor_west}, 32'd0);
        checkOutput("stuck_clr_count", bus.veh_count, 32'd0);

        // Count saturation, then clear colliding with a qualification.
        for (int v = 0; v < 300; v++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0, 5);
            applyStimulus(4'b0000, 1'b0, 1'b0, 5);
        end
        checkOutput("sat_count", {24'd0, bus.veh_count[7:0]}, 32'd255);
        applyStimulus(4'b0000, 1'b0, 1'b0, 20);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("sat_cleared", {24'd0, bus.veh_count[7:0]}, 32'd0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1);
        checkOutput("clr_vs_qual_sensor", {31'd0, bus.sensor_north}, 32'd1);
        checkOutput("clr_vs_qual_count", {24'd0, bus.veh_count[7:0]}, 32'd0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 3);
        checkOutput("clr_vs_qual_after", {24'd0, bus.veh_count[7:0]}, 32'd0);

        // Reset while every lane is in its hold extension.
        applyStimulus(4'b1111, 1'b0, 1'b0, 10);
        applyStimulus(4'b0000, 1'b0, 1'b0, 7);
        checkOutput("hold_all_sensor", {28'd0, dutSensor()}, 32'hF);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("rst_hold_sensor", {28'd0, dutSensor()}, 32'd0);
        checkOutput("rst_hold_count", bus.veh_count, 32'd0);
        checkOutput("rst_hold_fault", {28'd0, bus.fault}, 32'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0, 5);
        checkOutput("requal_early", {28'd0, dutSensor()}, 32'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0, 1);
        checkOutput("requal_sensor", {28'd0, dutSensor()}, 32'hF);
        checkOutput("requal_count", bus.veh_count, 32'h0101_0101);

        // Random traffic on all lanes with occasional clears and resets.
        r = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 5) == 0) r[l] = ~r[l];
            end
            applyStimulus(r, ($urandom_range(0, 199) == 0), ($urandom_range(0, 499) == 0), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE, default 4, is the number of consecutive equal samples needed to qualify an edge (range 1..15).
REQ-002 Parameter HOLD, default 8, is the presence-extension time in cycles after a qualified release (range 1..255).
REQ-003 Parameter STUCK, default 1000, is the number of continuous PRESENT cycles that flags a stuck loop (range 1..65535).
REQ-004 Port: clk, input, 1 bit; the single clock. All logic is on its rising edge.
REQ-005 Port: rst, input, 1 bit; synchronous, active-high reset.
REQ-006 Ports: raw_north, raw_east, raw_south, raw_west, input, 1 bit each; asynchronous loop-detector levels.
REQ-007 Port: clr_counts, input, 1 bit; synchronous clear of vehicle counts and fault flags.
REQ-008 Ports: sensor_north, sensor_east, sensor_south, sensor_west, output, 1 bit each; qualified presence, fed to the signal controller's sensor inputs.
REQ-009 Port: veh_count, output, 32 bits; four 8-bit counts packed as {W,S,E,N}, with N in bits 7:0.
REQ-010 Port: fault, output, 4 bits; stuck-loop flags, bit0=N, bit1=E, bit2=S, bit3=W.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchroniser; its output s_in SHALL drive that lane's FSM.
REQ-012 Each lane FSM SHALL have exactly five states: IDLE, QUAL_ON, PRESENT, QUAL_OFF and HOLD, plus a cnt counter and a registered sensor bit.
REQ-013 IDLE, s_in=1: go to PRESENT if DEBOUNCE=1, otherwise go to QUAL_ON with cnt=1.
REQ-014 QUAL_ON, s_in=1: at cnt=DEBOUNCE-1 go to PRESENT, otherwise increment cnt. QUAL_ON, s_in=0: go to IDLE and clear sensor.
REQ-015 Entering PRESENT from QUAL_ON or IDLE SHALL set sensor=1 and increment the lane count; the count saturates at 255.
REQ-016 PRESENT, s_in=0: go to QUAL_OFF with cnt=1 (to PRESENT->HOLD directly when DEBOUNCE=1). QUAL_OFF, s_in=1: return to PRESENT with no count increment.
REQ-017 QUAL_OFF, s_in=0: at cnt=DEBOUNCE-1 go to HOLD with cnt=1, otherwise increment cnt. sensor stays 1 throughout.
REQ-018 HOLD, s_in=0: after HOLD cycles in HOLD, go to IDLE and clear sensor. HOLD, s_in=1: go to QUAL_ON with cnt=1, sensor stays 1.
REQ-019 A stuck counter SHALL increment every cycle the lane is in PRESENT and clear whenever it is in any other state. Reaching STUCK sets that lane's fault bit (sticky).
REQ-020 While a lane's fault bit is 1, its sensor output SHALL be forced to 1 (fail-safe: the lane keeps being served). The FSM keeps running.
REQ-021 clr_counts=1 SHALL zero all counts and fault bits on the next edge; clear wins over a same-cycle increment or fault set.
REQ-022 Latency with raw stable: sensor rises 2+DEBOUNCE edges after raw rises (6 at default); falls 2+DEBOUNCE+HOLD edges after raw falls (14 at default).
REQ-023 Lanes SHALL be fully independent; simultaneous events on different lanes SHALL have no interaction.
REQ-024 All outputs SHALL be registered, with no combinational path from any input.

Reset
REQ-025 rst=1 SHALL set all FSMs to IDLE and clear cnt, the stuck counters, synchronisers, sensor_*, veh_count and fault on the next edge; rst overrides clr_counts.
REQ-026 rst asserted mid-qualification or mid-HOLD SHALL drop sensor to 0 on the next edge, with no count increment.

Structure
REQ-027 A shared package SHALL hold the lane index constants (N=0, E=1, S=2, W=3), the lane FSM state encoding, and the default DEBOUNCE, HOLD and STUCK values.
REQ-028 One sub-module, lane_qualifier, SHALL contain a single lane's FSM, counters and flags; sensor_conditioner SHALL instantiate it four times, together with the synchronisers and output packing.

Verification
REQ-029 raw_north high for 20 cycles -> sensor_north rises 6 edges after raw rises and falls 14 edges after raw falls; veh_count[7:0]=1.
REQ-030 raw_east pulses of 3 cycles, repeated 5 times with 10-cycle gaps -> sensor_east stays 0 and veh_count[15:8]=0.
REQ-031 raw_south high 10 cycles, low 5 cycles, high 10 cycles -> sensor_south stays 1 throughout; veh_count[23:16]=2.
REQ-032 raw_west held high for 1100 cycles -> fault[3]=1 at cycle 1006 ±1. After raw falls, sensor_west stays 1 until clr_counts, then falls once HOLD expires.
REQ-033 Count saturation and clear: 300 qualified north vehicles -> veh_count[7:0]=255. Pulse clr_counts in the same cycle as a qualification -> count reads 0.
REQ-034 Reset mid-operation: assert rst during HOLD on all four lanes -> every output is 0 on the next edge, and the lane needs a fresh 4-sample qualification to reassert.
